// File: rtl/value_cmd_pkg.sv
// value_cmd_pkg: shared state, opcode and blanking definitions for the value command sequencer
package value_cmd_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MRU_CMD,
    S_MRU_WAIT,
    S_BCD_CMD,
    S_BCD_WAIT,
    S_LATCH
  } state_t;
  typedef enum logic {
    OP_GET = 1'b0,
    OP_SET = 1'b1
  } op_t;
  localparam logic [3:0] BLANK = 4'hF;
endpackage

// File: rtl/value_cmd_blank.sv
// value_cmd_blank: leading-zero blanking of BCD digits into eight display nibbles
module value_cmd_blank
  import value_cmd_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] i_digits,
  output logic [31:0]         o_disp
);
  logic w_seen;
  // scan from the top digit down; once a nonzero digit (or digit 0) is seen, show the rest
  always_comb begin
    o_disp = {8{BLANK}};
    w_seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_seen = w_seen | (|i_digits[4*i +: 4]) | (i == 0);
      o_disp[4*i +: 4] = w_seen ? i_digits[4*i +: 4] : BLANK;
    end
  end
endmodule

// File: rtl/value_cmd_ctrl.sv
// value_cmd_ctrl: sequences set/get requests through the value store and BCD converter
module value_cmd_ctrl
  import value_cmd_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGITS  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                set_i,
  input  logic                get_i,
  input  logic [WIDTH-1:0]    switch,
  output logic                mru_start,
  output logic                mru_we,
  output logic [WIDTH-1:0]    mru_wdata,
  input  logic                mru_done,
  input  logic [WIDTH-1:0]    mru_rdata,
  output logic                bcd_start,
  output logic [WIDTH-1:0]    bcd_bin,
  input  logic                bcd_done,
  input  logic [4*DIGITS-1:0] bcd_digits,
  output logic [31:0]         disp_digits,
  output logic                disp_valid,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  state_t              r_state;
  op_t                 r_op, r_pop, w_a_op, w_b_op;
  logic                r_pv, r_set_d, r_get_d, w_set, w_get, w_a_v, w_b_v, w_drop;
  logic [WIDTH-1:0]    r_data, r_pd, w_a_data;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_digits;
  logic [31:0]         w_blank, r_disp;
  logic                r_mru_start, r_mru_we, r_bcd_start, r_disp_valid, r_err;
  logic [WIDTH-1:0]    r_mru_wdata, r_bcd_bin;
  assign w_set = en & set_i & ~r_set_d;
  assign w_get = en & get_i & ~r_get_d;
  // candidates ordered pending, set, get: first one runs (or is held), second queues, third drops
  assign w_a_v    = r_pv | w_set | w_get;
  assign w_b_v    = (r_pv & (w_set | w_get)) | (w_set & w_get);
  assign w_a_op   = r_pv ? r_pop : (w_set ? OP_SET : OP_GET);
  assign w_b_op   = (r_pv & w_set) ? OP_SET : OP_GET;
  assign w_a_data = r_pv ? r_pd : switch;
  assign w_drop   = (r_state == S_IDLE) ? (r_pv & w_set & w_get) : w_b_v;
  value_cmd_blank #(.DIGITS(DIGITS)) u_blank (.i_digits(r_digits), .o_disp(w_blank));
  assign mru_start   = r_mru_start;
  assign mru_we      = r_mru_we;
  assign mru_wdata   = r_mru_wdata;
  assign bcd_start   = r_bcd_start;
  assign bcd_bin     = r_bcd_bin;
  assign disp_digits = r_disp;
  assign disp_valid  = r_disp_valid;
  assign busy        = r_state != S_IDLE;
  assign err         = r_err;
  // command sequencer: edge capture, pending slot, store/converter handshakes and timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_set_d      <= 1'b0;
      r_get_d      <= 1'b0;
      r_pv         <= 1'b0;
      r_pop        <= OP_GET;
      r_pd         <= '0;
      r_op         <= OP_GET;
      r_data       <= '0;
      r_cnt        <= '0;
      r_digits     <= '0;
      r_mru_start  <= 1'b0;
      r_mru_we     <= 1'b0;
      r_mru_wdata  <= '0;
      r_bcd_start  <= 1'b0;
      r_bcd_bin    <= '0;
      r_disp       <= '1;
      r_disp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mru_start <= 1'b0;
      r_bcd_start <= 1'b0;
      if (en) begin
        r_set_d <= set_i;
        r_get_d <= get_i;
        r_err   <= r_err | w_drop;
        if (r_state != S_IDLE && !r_pv) begin
          r_pv  <= w_a_v;
          r_pop <= w_a_op;
          r_pd  <= w_a_data;
        end
        case (r_state)
          S_IDLE: if (w_a_v) begin
            r_op    <= w_a_op;
            r_data  <= w_a_data;
            r_pv    <= w_b_v;
            r_pop   <= w_b_op;
            r_pd    <= switch;
            r_state <= S_MRU_CMD;
          end
          S_MRU_CMD: begin
            r_mru_start <= 1'b1;
            r_mru_we    <= r_op == OP_SET;
            r_mru_wdata <= r_data;
            r_cnt       <= '0;
            r_state     <= S_MRU_WAIT;
          end
          S_MRU_WAIT: if (mru_done) begin
            r_bcd_bin <= (r_op == OP_SET) ? r_data : mru_rdata;
            r_state   <= S_BCD_CMD;
          end else if (r_cnt == TMAX) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
          S_BCD_CMD: begin
            r_bcd_start <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_BCD_WAIT;
          end
          S_BCD_WAIT: if (bcd_done) begin
            r_digits <= bcd_digits;
            r_state  <= S_LATCH;
          end else if (r_cnt == TMAX) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
          S_LATCH: begin
            r_disp       <= w_blank;
            r_disp_valid <= 1'b1;
            r_state      <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_value_cmd_ctrl.sv
// tb_value_cmd_ctrl: scenario tests and randomized traffic against a decimal display model
module tb_value_cmd_ctrl;
  localparam int W = 16, D = 5, TO = 1024, LIM = TO + 64;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, set_i = 1'b0, get_i = 1'b0, mru_done = 1'b0, bcd_done = 1'b0;
  logic [W-1:0] switch_v = '0, mru_rdata = '0;
  logic [4*D-1:0] bcd_digits = '0;
  logic mru_start, mru_we, bcd_start, disp_valid, busy, err;
  logic [W-1:0] mru_wdata, bcd_bin;
  logic [31:0] disp_digits;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  value_cmd_ctrl #(.WIDTH(W), .DIGITS(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .set_i(set_i), .get_i(get_i), .switch(switch_v),
    .mru_start(mru_start), .mru_we(mru_we), .mru_wdata(mru_wdata), .mru_done(mru_done),
    .mru_rdata(mru_rdata), .bcd_start(bcd_start), .bcd_bin(bcd_bin), .bcd_done(bcd_done),
    .bcd_digits(bcd_digits), .disp_digits(disp_digits), .disp_valid(disp_valid),
    .busy(busy), .err(err)
  );
  function automatic logic [4*D-1:0] bcd_of(input int v);
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic [31:0] exp_disp(input int v);
    logic [31:0] r;
    r = '1;
    for (int i = 0; i == 0 || v != 0; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic [W-1:0] rand_val();
    return W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; en = 1'b1; set_i = 1'b0; get_i = 1'b0; mru_done = 1'b0; bcd_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic pulse(input logic s, input logic g, input logic [W-1:0] v);
    switch_v = v; set_i = s; get_i = g;
    step();
    set_i = 1'b0; get_i = 1'b0;
  endtask
  task automatic wait_mru(output int n, output logic we, output logic [W-1:0] wd);
    n = -1; we = 1'b0; wd = '0;
    for (int k = 1; k <= LIM; k++) begin
      step();
      if (mru_start) begin n = k; we = mru_we; wd = mru_wdata; break; end
    end
  endtask
  task automatic mru_reply(input int lat, input logic [W-1:0] rd);
    repeat (lat) step();
    mru_done = 1'b1; mru_rdata = rd;
    step();
    mru_done = 1'b0;
  endtask
  task automatic wait_bcd(output int n, output logic [W-1:0] b);
    n = -1; b = '0;
    for (int k = 1; k <= LIM; k++) begin
      step();
      if (bcd_start) begin n = k; b = bcd_bin; break; end
    end
  endtask
  task automatic bcd_reply(input int lat, input logic [4*D-1:0] dg);
    repeat (lat) step();
    bcd_done = 1'b1; bcd_digits = dg;
    step();
    bcd_done = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = -1;
    for (int k = 1; k <= LIM; k++) begin
      step();
      if (!busy) begin n = k; break; end
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if ({mru_start, mru_we, bcd_start, disp_valid, busy, err} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {mru_start, mru_we, bcd_start, disp_valid, busy, err}); end
    checks++; if (mru_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", mru_wdata); end
    checks++; if (bcd_bin !== '0) begin errors++; $display("FAIL reset_bin: got %0h expected 0", bcd_bin); end
    checks++; if (disp_digits !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_disp: got %h expected ffffffff", disp_digits); end
    mru_done = 1'b1; bcd_done = 1'b1;
    step();
    mru_done = 1'b0; bcd_done = 1'b0;
    step();
    checks++; if ({busy, disp_valid} !== 2'b00) begin errors++; $display("FAIL idle_stray_done: got %b expected 00", {busy, disp_valid}); end
  endtask
  task automatic test_set();
    int n; logic we; logic [W-1:0] wd, b;
    do_reset();
    pulse(1'b1, 1'b0, 16'd65233);
    wait_mru(n, we, wd);
    checks++; if (n !== 1) begin errors++; $display("FAIL set_start_lat: got %0d expected 1", n); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL set_we: got %b expected 1", we); end
    checks++; if (wd !== 16'd65233) begin errors++; $display("FAIL set_wdata: got %0d expected 65233", wd); end
    mru_reply(3, '0);
    wait_bcd(n, b);
    checks++; if (n !== 1) begin errors++; $display("FAIL set_bcd_lat: got %0d expected 1", n); end
    checks++; if (b !== 16'd65233) begin errors++; $display("FAIL set_bin: got %0d expected 65233", b); end
    bcd_reply(2, 20'h65233);
    wait_idle(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL set_latch_lat: got %0d expected 1", n); end
    checks++; if (disp_digits !== 32'hFFF6_5233) begin errors++; $display("FAIL set_disp: got %h expected fff65233", disp_digits); end
    checks++; if ({disp_valid, err} !== 2'b10) begin errors++; $display("FAIL set_valid_err: got %b expected 10", {disp_valid, err}); end
  endtask
  task automatic test_get();
    int n; logic we; logic [W-1:0] wd, b, rd; logic [31:0] ex;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rd = (i == 0) ? 16'd42 : 16'd0;
      ex = (i == 0) ? 32'hFFFF_FF42 : 32'hFFFF_FFF0;
      pulse(1'b0, 1'b1, rand_val());
      wait_mru(n, we, wd);
      checks++; if (we !== 1'b0 || n !== 1) begin errors++; $display("FAIL get_we: got we=%b lat=%0d expected we=0 lat=1", we, n); end
      bcd_done = 1'b1;
      step();
      bcd_done = 1'b0;
      mru_reply(1, rd);
      wait_bcd(n, b);
      checks++; if (b !== rd) begin errors++; $display("FAIL get_bin: got %0d expected %0d", b, rd); end
      bcd_reply(1, bcd_of(int'(b)));
      wait_idle(n);
      checks++; if (disp_digits !== ex) begin errors++; $display("FAIL get_disp: got %h expected %h", disp_digits, ex); end
    end
  endtask
  task automatic test_back_to_back();
    int n, extra; logic we; logic [W-1:0] wd, b, v, r2;
    do_reset();
    v = rand_val(); r2 = rand_val();
    pulse(1'b1, 1'b1, v);
    wait_mru(n, we, wd);
    checks++; if (we !== 1'b1 || wd !== v) begin errors++; $display("FAIL b2b_first: got we=%b wd=%0d expected we=1 wd=%0d", we, wd, v); end
    get_i = 1'b1;
    step();
    get_i = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_drop_err: got %b expected 1", err); end
    mru_reply(2, '0);
    wait_bcd(n, b);
    checks++; if (b !== v) begin errors++; $display("FAIL b2b_bin1: got %0d expected %0d", b, v); end
    bcd_reply(2, bcd_of(int'(b)));
    wait_idle(n);
    checks++; if (disp_digits !== exp_disp(int'(v))) begin errors++; $display("FAIL b2b_disp1: got %h expected %h", disp_digits, exp_disp(int'(v))); end
    wait_mru(n, we, wd);
    checks++; if (n !== 2 || we !== 1'b0) begin errors++; $display("FAIL b2b_second: got lat=%0d we=%b expected lat=2 we=0", n, we); end
    mru_reply(1, r2);
    wait_bcd(n, b);
    checks++; if (b !== r2) begin errors++; $display("FAIL b2b_bin2: got %0d expected %0d", b, r2); end
    bcd_reply(1, bcd_of(int'(b)));
    wait_idle(n);
    checks++; if (disp_digits !== exp_disp(int'(r2))) begin errors++; $display("FAIL b2b_disp2: got %h expected %h", disp_digits, exp_disp(int'(r2))); end
    extra = 0;
    repeat (8) begin step(); extra += int'(mru_start); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_no_third: got %0d starts expected 0", extra); end
  endtask
  task automatic test_timeout();
    int n; logic we; logic [W-1:0] wd, b, v, v2;
    do_reset();
    v = rand_val(); v2 = rand_val();
    pulse(1'b1, 1'b0, v);
    wait_mru(n, we, wd);
    mru_reply(1, '0);
    wait_bcd(n, b);
    bcd_reply(1, bcd_of(int'(b)));
    wait_idle(n);
    pulse(1'b0, 1'b1, '0);
    wait_mru(n, we, wd);
    wait_idle(n);
    checks++; if (n !== TO) begin errors++; $display("FAIL to_cycles: got %0d expected %0d", n, TO); end
    checks++; if ({err, disp_valid} !== 2'b11) begin errors++; $display("FAIL to_err: got %b expected 11", {err, disp_valid}); end
    checks++; if (disp_digits !== exp_disp(int'(v))) begin errors++; $display("FAIL to_disp_kept: got %h expected %h", disp_digits, exp_disp(int'(v))); end
    mru_reply(0, 16'hBEEF);
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_late_done: got busy=%b expected 0", busy); end
    pulse(1'b1, 1'b0, v2);
    wait_mru(n, we, wd);
    checks++; if (we !== 1'b1 || wd !== v2) begin errors++; $display("FAIL to_next_cmd: got we=%b wd=%0d expected we=1 wd=%0d", we, wd, v2); end
    mru_reply(2, '0);
    wait_bcd(n, b);
    bcd_reply(2, bcd_of(int'(b)));
    wait_idle(n);
    checks++; if (disp_digits !== exp_disp(int'(v2))) begin errors++; $display("FAIL to_next_disp: got %h expected %h", disp_digits, exp_disp(int'(v2))); end
  endtask
  task automatic test_rst_mid();
    int n, extra; logic we; logic [W-1:0] wd, b, v;
    do_reset();
    v = W'($urandom_range(1, 65535));
    pulse(1'b1, 1'b1, v);
    wait_mru(n, we, wd);
    mru_reply(1, '0);
    wait_bcd(n, b);
    checks++; if (n !== 1 || b !== v) begin errors++; $display("FAIL rst_mid_reach: got lat=%0d bin=%0d expected lat=1 bin=%0d", n, b, v); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({mru_start, mru_we, bcd_start, disp_valid, busy, err} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 000000", {mru_start, mru_we, bcd_start, disp_valid, busy, err}); end
    checks++; if (mru_wdata !== '0 || bcd_bin !== '0) begin errors++; $display("FAIL rst_mid_data: got wd=%0d bin=%0d expected 0 0", mru_wdata, bcd_bin); end
    checks++; if (disp_digits !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_disp: got %h expected ffffffff", disp_digits); end
    extra = 0;
    repeat (10) begin step(); extra += int'(mru_start) + int'(busy); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rst_mid_pending: got %0d activity expected 0", extra); end
  endtask
  task automatic test_en_hold();
    int n, strobes; logic we; logic [W-1:0] wd, b, v;
    do_reset();
    v = rand_val();
    pulse(1'b1, 1'b0, v);
    wait_mru(n, we, wd);
    en = 1'b0;
    strobes = 0;
    repeat (TO + 50) begin step(); strobes += int'(mru_start) + int'(bcd_start); end
    checks++; if ({busy, err} !== 2'b10) begin errors++; $display("FAIL en_hold_state: got %b expected 10", {busy, err}); end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL en_hold_strobes: got %0d expected 0", strobes); end
    en = 1'b1;
    mru_reply(1, '0);
    wait_bcd(n, b);
    checks++; if (n !== 1 || b !== v) begin errors++; $display("FAIL en_resume_bin: got lat=%0d bin=%0d expected lat=1 bin=%0d", n, b, v); end
    bcd_reply(1, bcd_of(int'(b)));
    wait_idle(n);
    checks++; if (disp_digits !== exp_disp(int'(v)) || err !== 1'b0) begin errors++; $display("FAIL en_resume_disp: got %h err=%b expected %h err=0", disp_digits, err, exp_disp(int'(v))); end
  endtask
  task automatic test_random();
    int n, mode; logic we; logic [W-1:0] wd, b, v, mem, ex; bit ops[$]; bit op;
    do_reset();
    mem = rand_val();
    for (int it = 0; it < 25; it++) begin
      mode = int'($urandom_range(0, 2));
      v = rand_val();
      ops = {};
      if (mode != 1) ops.push_back(1'b1);
      if (mode != 0) ops.push_back(1'b0);
      pulse(mode != 1, mode != 0, v);
      while (ops.size() > 0) begin
        op = ops.pop_front();
        if (op) mem = v;
        ex = mem;
        wait_mru(n, we, wd);
        checks++; if (we !== op || (op && wd !== v)) begin errors++; $display("FAIL rnd_mru: got we=%b wd=%0d expected we=%b wd=%0d", we, wd, op, v); end
        mru_reply(int'($urandom_range(0, 5)), mem);
        wait_bcd(n, b);
        checks++; if (b !== ex) begin errors++; $display("FAIL rnd_bin: got %0d expected %0d", b, ex); end
        bcd_reply(int'($urandom_range(0, 5)), bcd_of(int'(b)));
        wait_idle(n);
        checks++; if (disp_digits !== exp_disp(int'(ex)) || disp_valid !== 1'b1) begin errors++; $display("FAIL rnd_disp: got %h v=%b expected %h v=1", disp_digits, disp_valid, exp_disp(int'(ex))); end
      end
      repeat ($urandom_range(0, 3)) step();
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err: got %b expected 0", err); end
  endtask
  initial begin
    test_reset();
    test_set();
    test_get();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_en_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
